alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_core.sv | 61 ++++++
 rtl/alu_seq.sv | 130 +++++++++++++
 tb/tb_alu_seq.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag bit positions and FSM state type shared by the
// alu_seq block and its combinational core.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_ASR = 3'd7
    } op_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_e;

    function automatic logic [3:0] pack_flags(
        input logic n,
        input logic z,
        input logic c,
        input logic v
    );
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core: single-cycle ADD/SUB/AND/OR/XOR datapath with NZCV generation.
// Define ALU_SAT_EN to clamp ADD on carry and SUB on borrow.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       op_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] res_o,
    output logic [3:0]       flags_o
);

    op_e              op;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] res;
    logic             c;
    logic             v;

    assign op = op_e'(op_i);

    always_comb begin
        sum  = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
        diff = {1'b0, a_i} - {1'b0, b_i} - {{WIDTH{1'b0}}, cin_i};
        raw  = '0;
        c    = 1'b0;
        v    = 1'b0;
        unique case (op)
            OP_ADD: begin
                raw = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (a_i[WIDTH-1] == b_i[WIDTH-1])
                    && (raw[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SUB: begin
                // A negative difference wraps, so the top bit is the borrow
                raw = diff[WIDTH-1:0];
                c   = diff[WIDTH];
                v   = (a_i[WIDTH-1] != b_i[WIDTH-1])
                    && (raw[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_AND:  raw = a_i & b_i;
            OP_OR:   raw = a_i | b_i;
            OP_XOR:  raw = a_i ^ b_i;
            default: raw = '0;
        endcase

        res = raw;
`ifdef ALU_SAT_EN
        if (op == OP_ADD && c) res = '1;
        if (op == OP_SUB && c) res = '0;
`endif
        res_o   = res;
        flags_o = pack_flags(res[WIDTH-1], res == '0, c, v);
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU; logic/arith ops finish in one cycle, shifts
// step one bit per cycle. Result and flags are held until out_ready.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    input  logic [2:0]       opcode,
    input  logic             status_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             status_out,
    output logic [3:0]       flags
);

    localparam int SHAMT_W = $clog2(WIDTH);

    state_e             state_q;
    op_e                op_q;
    logic [WIDTH-1:0]   sh_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic [WIDTH-1:0]   result_q;
    logic [3:0]         flags_q;
    logic               out_valid_q;

    op_e                op_in;
    logic               is_shift;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   core_res;
    logic [3:0]         core_flags;
    logic [WIDTH-1:0]   sh_nxt;
    logic               sh_c;

    assign op_in    = op_e'(opcode);
    assign is_shift = op_in inside {OP_SHL, OP_SHR, OP_ASR};
    assign shamt    = right[SHAMT_W-1:0];

    alu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a_i    (left),
        .b_i    (right),
        .op_i   (opcode),
        .cin_i  (status_in),
        .res_o  (core_res),
        .flags_o(core_flags)
    );

    // One-bit shift step; sh_c is the bit leaving the register
    always_comb begin
        sh_nxt = sh_q;
        sh_c   = 1'b0;
        unique case (op_q)
            OP_SHL:  {sh_c, sh_nxt} = {sh_q, 1'b0};
            OP_SHR:  {sh_nxt, sh_c} = {1'b0, sh_q};
            OP_ASR:  {sh_nxt, sh_c} = {sh_q[WIDTH-1], sh_q};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_ADD;
            sh_q        <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        if (!is_shift) begin
                            result_q    <= core_res;
                            flags_q     <= core_flags;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else if (shamt == '0) begin
                            result_q    <= left;
                            flags_q     <= pack_flags(left[WIDTH-1],
                                                      left == '0,
                                                      1'b0, 1'b0);
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            sh_q    <= left;
                            cnt_q   <= shamt;
                            op_q    <= op_in;
                            state_q <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    sh_q  <= sh_nxt;
                    cnt_q <= cnt_q - SHAMT_W'(1);
                    if (cnt_q == SHAMT_W'(1)) begin
                        result_q    <= sh_nxt;
                        flags_q     <= pack_flags(sh_nxt[WIDTH-1],
                                                  sh_nxt == '0,
                                                  sh_c, 1'b0);
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign flags      = flags_q;
    assign status_out = flags_q[FLAG_C];

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq at WIDTH=8.
module tb_alu_seq;

    localparam logic [2:0] ADD = 3'd0;
    localparam logic [2:0] SUB = 3'd1;
    localparam logic [2:0] AND = 3'd2;
    localparam logic [2:0] OR  = 3'd3;
    localparam logic [2:0] XOR = 3'd4;
    localparam logic [2:0] SHL = 3'd5;
    localparam logic [2:0] SHR = 3'd6;
    localparam logic [2:0] ASR = 3'd7;

    typedef struct {
        string      name;
        logic [2:0] op;
        logic [7:0] l;
        logic [7:0] r;
        logic       cin;
        logic [7:0] res;
        logic [3:0] fl;
        int         lat;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] left;
    logic [7:0] right;
    logic [2:0] opcode;
    logic       status_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       status_out;
    logic [3:0] flags;

    int checks   = 0;
    int failures = 0;

    alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .left      (left),
        .right     (right),
        .opcode    (opcode),
        .status_in (status_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .status_out(status_out),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Present one operation, accept it, scramble inputs, wait for out_valid.
    task automatic run_op(input logic [2:0] op, input logic [7:0] l,
                          input logic [7:0] r, input logic cin,
                          output int lat);
        opcode = op; left = l; right = r; status_in = cin;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        left = 8'h3C; right = 8'hC3; opcode = SUB; status_in = 1'b1;
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_table(input vec_t v[$]);
        int lat;
        foreach (v[k]) begin
            run_op(v[k].op, v[k].l, v[k].r, v[k].cin, lat);
            checks++;
            if (lat !== v[k].lat) begin
                failures++;
                $display("FAIL %s latency got=%0d exp=%0d", v[k].name, lat, v[k].lat);
            end
            checks++;
            if (result !== v[k].res) begin
                failures++;
                $display("FAIL %s result got=%h exp=%h", v[k].name, result, v[k].res);
            end
            checks++;
            if (flags !== v[k].fl) begin
                failures++;
                $display("FAIL %s flags got=%b exp=%b", v[k].name, flags, v[k].fl);
            end
            checks++;
            if (status_out !== v[k].fl[1]) begin
                failures++;
                $display("FAIL %s status_out got=%b exp=%b", v[k].name, status_out, v[k].fl[1]);
            end
            finish_op();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL %s release got ov=%b ir=%b exp ov=0 ir=1", v[k].name, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        left = '0; right = '0; opcode = ADD; status_in = 1'b0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || result !== 8'h00 || flags !== 4'h0 || status_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got ov=%b res=%h fl=%b st=%b exp all 0", out_valid, result, flags, status_out);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset got ir=%b ov=%b exp ir=1 ov=0", in_ready, out_valid);
        end
    endtask

    task automatic test_arith();
        vec_t v[$];
`ifdef ALU_SAT_EN
        v.push_back('{"add_ff_01", ADD, 8'hFF, 8'h01, 1'b0, 8'hFF, 4'b1010, 1});
        v.push_back('{"sub_00_01", SUB, 8'h00, 8'h01, 1'b0, 8'h00, 4'b0110, 1});
`else
        v.push_back('{"add_ff_01", ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b0110, 1});
        v.push_back('{"sub_00_01", SUB, 8'h00, 8'h01, 1'b0, 8'hFF, 4'b1010, 1});
`endif
        v.push_back('{"add_7f_01", ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b1001, 1});
        v.push_back('{"add_cin",   ADD, 8'h10, 8'h20, 1'b1, 8'h31, 4'b0000, 1});
        v.push_back('{"sub_80_01", SUB, 8'h80, 8'h01, 1'b0, 8'h7F, 4'b0001, 1});
        v.push_back('{"sub_bin",   SUB, 8'h05, 8'h02, 1'b1, 8'h02, 4'b0000, 1});
        v.push_back('{"sub_eq",    SUB, 8'h05, 8'h05, 1'b0, 8'h00, 4'b0100, 1});
        run_table(v);
    endtask

    task automatic test_logic();
        vec_t v[$];
        v.push_back('{"and", AND, 8'hF0, 8'h3C, 1'b1, 8'h30, 4'b0000, 1});
        v.push_back('{"or",  OR,  8'h0F, 8'h80, 1'b0, 8'h8F, 4'b1000, 1});
        v.push_back('{"xor", XOR, 8'hAA, 8'hAA, 1'b1, 8'h00, 4'b0100, 1});
        run_table(v);
    endtask

    task automatic test_shift();
        vec_t v[$];
        v.push_back('{"shl_aa_3", SHL, 8'hAA, 8'h03, 1'b0, 8'h50, 4'b0010, 4});
        v.push_back('{"asr_80_7", ASR, 8'h80, 8'h07, 1'b0, 8'hFF, 4'b1000, 8});
        v.push_back('{"shr_80_7", SHR, 8'h80, 8'h07, 1'b0, 8'h01, 4'b0000, 8});
        v.push_back('{"shl_by_0", SHL, 8'h81, 8'h08, 1'b1, 8'h81, 4'b1000, 1});
        v.push_back('{"shr_03_1", SHR, 8'h03, 8'h01, 1'b0, 8'h01, 4'b0010, 2});
        v.push_back('{"asr_7f_2", ASR, 8'h7F, 8'h02, 1'b0, 8'h1F, 4'b0010, 3});
        run_table(v);
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(ADD, 8'h7F, 8'h01, 1'b0, lat);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            left = 8'(i * 17 + 1); right = 8'(8'hF0 - i); opcode = 3'(i);
            @(posedge clk); #1;
            checks++;
            if (result !== 8'h80 || flags !== 4'b1001) begin
                failures++;
                $display("FAIL bp_hold[%0d] got res=%h fl=%b exp res=80 fl=1001", i, result, flags);
            end
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL bp_handshake[%0d] got ir=%b ov=%b exp ir=0 ov=1", i, in_ready, out_valid);
            end
        end
        opcode = ADD; left = 8'h01; right = 8'h02; status_in = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release got ir=%b ov=%b exp ir=1 ov=0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 8'h03 || flags !== 4'b0000) begin
            failures++;
            $display("FAIL bp_next got ov=%b res=%h fl=%b exp ov=1 res=03 fl=0000", out_valid, result, flags);
        end
        finish_op();
    endtask

    task automatic test_reset_mid_shift();
        int lat;
        int seen;
        opcode = SHL; left = 8'h01; right = 8'h07; status_in = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 8'h00 || flags !== 4'h0 || status_out !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_outputs got ov=%b res=%h fl=%b st=%b exp all 0", out_valid, result, flags, status_out);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_in_ready got=%b exp=1", in_ready);
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL rst_mid_no_pulse got=%0d exp=0 cycles with out_valid", seen);
        end
        run_op(ADD, 8'h01, 8'h01, 1'b0, lat);
        checks++;
        if (result !== 8'h02 || flags !== 4'b0000 || lat !== 1) begin
            failures++;
            $display("FAIL rst_mid_add got res=%h fl=%b lat=%0d exp res=02 fl=0000 lat=1", result, flags, lat);
        end
        finish_op();
    endtask

    initial begin
        test_reset();
        test_arith();
        test_logic();
        test_shift();
        test_back_to_back();
        test_reset_mid_shift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
